// File: rtl/key_debounce_if.sv
// Key conditioner bundle: raw board pins in, debounced level/pulses/toggle out.
// Latency: none (wires only).
// Backpressure: none; the pins free-run and consumers sample every cycle.
//
// Signals:
//   key_raw     raw asynchronous key pins (driven by master)
//   key_clean   debounced level, 1 = pressed
//   key_press   one-cycle pulse on clean 0->1
//   key_release one-cycle pulse on clean 1->0
//   key_toggle  flips on every press
interface key_debounce_if #(
  parameter int w_key = 4
);
  logic [w_key-1:0] key_raw;
  logic [w_key-1:0] key_clean;
  logic [w_key-1:0] key_press;
  logic [w_key-1:0] key_release;
  logic [w_key-1:0] key_toggle;

  // master: board/pin side that drives the raw keys and consumes the results
  modport master (
    output key_raw,
    input  key_clean,
    input  key_press,
    input  key_release,
    input  key_toggle
  );

  // slave: the conditioner itself
  modport slave (
    input  key_raw,
    output key_clean,
    output key_press,
    output key_release,
    output key_toggle
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchronizer + stability-counter debouncer + edge/toggle generation.
// Latency: stable_cycles + 2 edges from a settled pin change to key_clean/key_press/key_release.
// Backpressure: none; pulses are single-cycle and must be sampled when they occur.
//
// Ports:
//   clk  single rising-edge clock
//   rst  synchronous active-high reset (clears every register)
//   kif  key_debounce_if.slave: key_raw in; key_clean/key_press/key_release/key_toggle out
module key_debounce #(
  parameter int clk_mhz        = 50,
  parameter int w_key          = 4,
  parameter int debounce_ms    = 10,
  parameter int stable_cycles  = clk_mhz * 1000 * debounce_ms,
  parameter bit key_active_low = 1'b0,
  parameter int w_cnt          = $clog2(stable_cycles + 1)
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  kif
);

  localparam logic [w_cnt-1:0] cnt_max = w_cnt'(stable_cycles - 1);

  logic [w_key-1:0] p;
  logic [w_key-1:0] sync1;
  logic [w_key-1:0] s;
  logic [w_cnt-1:0] cnt [w_key];
  logic [w_key-1:0] clean_q;
  logic [w_key-1:0] press_q;
  logic [w_key-1:0] release_q;
  logic [w_key-1:0] toggle_q;

  // Normalize so that 1 always means "pressed" downstream of this point.
  assign p = key_active_low ? ~kif.key_raw : kif.key_raw;

  // Two-flop synchronizer; nothing sits between the flops so the first stage
  // has a full cycle to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= p;
      s     <= sync1;
    end
  end

  // Debounce: a key's clean level follows s only after s has disagreed with it
  // for stable_cycles consecutive cycles. Any agreeing cycle restarts the count,
  // so the counter tops out at cnt_max and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < w_key; i++) begin
        cnt[i] <= '0;
      end
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
    end else begin
      for (int i = 0; i < w_key; i++) begin
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
        if (s[i] == clean_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == cnt_max) begin
          // s differs from clean here, so s itself tells the edge direction.
          cnt[i]       <= '0;
          clean_q[i]   <= s[i];
          press_q[i]   <= s[i];
          release_q[i] <= ~s[i];
          toggle_q[i]  <= toggle_q[i] ^ s[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign kif.key_clean   = clean_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.key_toggle  = toggle_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with stable_cycles = 4 (press lands 5 edges
// after the first edge that samples a settled pin), plus an active-low copy.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  key_debounce_if #(.w_key(4)) kif ();
  key_debounce_if #(.w_key(4)) kif_al ();

  key_debounce #(
    .w_key(4), .stable_cycles(4), .key_active_low(1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  key_debounce #(
    .w_key(4), .stable_cycles(4), .key_active_low(1'b1)
  ) dut_al (
    .clk (clk),
    .rst (rst),
    .kif (kif_al.slave)
  );

  int total = 0;
  int bad   = 0;

  // monitors updated every tick
  logic [2:0] act_k1;
  logic [3:0] act_al;
  int         n_press2, n_rel2, n_wide2;
  logic       prev_press2, prev_rel2;
  bit         mon_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_on) begin
      act_k1 = act_k1 | {kif.key_press[1], kif.key_release[1], kif.key_clean[1]};
      act_al = act_al | kif_al.key_press | kif_al.key_release | kif_al.key_clean;
      if (kif.key_press[2]) n_press2++;
      if (kif.key_release[2]) n_rel2++;
      if ((kif.key_press[2] && prev_press2) || (kif.key_release[2] && prev_rel2)) n_wide2++;
      prev_press2 = kif.key_press[2];
      prev_rel2   = kif.key_release[2];
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [15:0] all_out();
    return {kif.key_clean, kif.key_press, kif.key_release, kif.key_toggle};
  endfunction

  initial begin
    kif.key_raw    = 4'b1111;
    kif_al.key_raw = 4'b1111;

    // ---- reset with all keys held ----
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_outs", {16'h0, all_out()}, 32'h0);
    end
    check("rst_al_outs", {16'h0, kif_al.key_clean, kif_al.key_press,
                          kif_al.key_release, kif_al.key_toggle}, 32'h0);
    act_k1 = '0; act_al = '0;
    n_press2 = 0; n_rel2 = 0; n_wide2 = 0;
    prev_press2 = 1'b0; prev_rel2 = 1'b0;
    mon_on = 1'b1;
    rst = 1'b0;
    step(5);
    check("rst_held_press_early", {28'h0, kif.key_press}, 32'h0);
    tick();
    check("rst_held_press", {28'h0, kif.key_press}, 32'hf);
    check("rst_held_clean", {28'h0, kif.key_clean}, 32'hf);
    check("rst_held_toggle", {28'h0, kif.key_toggle}, 32'hf);
    tick();
    check("rst_held_press_1cyc", {28'h0, kif.key_press}, 32'h0);

    // return to idle and clear toggles
    kif.key_raw = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    act_k1 = '0;
    step(8);
    check("idle_outs", {16'h0, all_out()}, 32'h0);

    // ---- clean press / hold / release on key 0 ----
    kif.key_raw = 4'b0001;
    step(5);
    check("k0_press_early", {28'h0, kif.key_press}, 32'h0);
    tick();
    check("k0_press", {28'h0, kif.key_press}, 32'h1);
    check("k0_clean", {28'h0, kif.key_clean}, 32'h1);
    tick();
    check("k0_press_1cyc", {28'h0, kif.key_press}, 32'h0);
    step(3);
    kif.key_raw = 4'b0000;
    step(5);
    check("k0_rel_early", {28'h0, kif.key_release}, 32'h0);
    check("k0_clean_held", {28'h0, kif.key_clean}, 32'h1);
    tick();
    check("k0_release", {28'h0, kif.key_release}, 32'h1);
    check("k0_clean_low", {28'h0, kif.key_clean}, 32'h0);
    check("k0_toggle_kept", {28'h0, kif.key_toggle}, 32'h1);
    tick();
    check("k0_rel_1cyc", {28'h0, kif.key_release}, 32'h0);

    // ---- glitch rejection on key 1 ----
    act_k1 = '0;
    kif.key_raw = 4'b0010; step(3);
    kif.key_raw = 4'b0000; step(1);
    kif.key_raw = 4'b0010; step(3);
    kif.key_raw = 4'b0000; step(8);
    check("k1_glitch_none", {29'h0, act_k1}, 32'h0);
    // 4-cycle pulse passes
    kif.key_raw = 4'b0010; step(4);
    kif.key_raw = 4'b0000; step(1);
    check("k1_pulse_early", {28'h0, kif.key_press}, 32'h0);
    tick();
    check("k1_pulse_press", {28'h0, kif.key_press}, 32'h2);
    step(10);
    check("k1_pulse_back_low", {28'h0, kif.key_clean}, 32'h0);

    // ---- toggle on key 2 ----
    n_press2 = 0; n_rel2 = 0; n_wide2 = 0;
    for (int r = 0; r < 3; r++) begin
      kif.key_raw = 4'b0100; step(10);
      check("k2_toggle", {31'h0, kif.key_toggle[2]}, (r == 1) ? 32'h0 : 32'h1);
      kif.key_raw = 4'b0000; step(10);
    end
    check("k2_n_press", n_press2, 3);
    check("k2_n_release", n_rel2, 3);
    check("k2_pulse_width", n_wide2, 0);

    // ---- simultaneous keys 0 and 3 ----
    kif.key_raw = 4'b1001;
    step(5);
    check("k03_press_early", {28'h0, kif.key_press}, 32'h0);
    tick();
    check("k03_press", {28'h0, kif.key_press}, 32'h9);

    // ---- reset mid-count on key 1 ----
    kif.key_raw = 4'b1011;
    step(4);
    rst = 1'b1;
    tick();
    check("midrst_outs", {16'h0, all_out()}, 32'h0);
    rst = 1'b0;
    step(5);
    check("midrst_press_early", {28'h0, kif.key_press}, 32'h0);
    tick();
    check("midrst_press", {28'h0, kif.key_press}, 32'hb);

    // ---- active-low copy ----
    check("al_idle_quiet", {28'h0, act_al}, 32'h0);
    // let the mid-count reset settle so the instance is idle again
    step(6);
    kif_al.key_raw = 4'b1110;
    step(5);
    check("al_press_early", {28'h0, kif_al.key_press}, 32'h0);
    tick();
    check("al_press", {28'h0, kif_al.key_press}, 32'h1);
    check("al_clean", {28'h0, kif_al.key_clean}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
